// File: rtl/ozer_alican_pr2_if.sv
// ozer_alican_pr2_if: instruction/result bus between the execution block and its driver
interface ozer_alican_pr2_if;
  logic [31:0] instr;
  logic [31:0] result;
  modport master (output instr, input result);
  modport slave (input instr, output result);
endinterface

// File: rtl/ozer_alican_pr2_top.sv
// ozer_alican_pr2_top: single-cycle MIPS R-type execute with 32x32 regfile; PR2_ZERO_REG_EN hardwires r0 to zero
module ozer_alican_pr2_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rda_o,
  output logic [31:0] rdb_o
);
  logic [31:0] memory [32];
  logic        we_eff;
`ifdef PR2_ZERO_REG_EN
  assign rda_o  = (ra_i == 5'd0) ? 32'd0 : memory[ra_i];
  assign rdb_o  = (rb_i == 5'd0) ? 32'd0 : memory[rb_i];
  assign we_eff = we_i && (wa_i != 5'd0);
`else
  assign rda_o  = memory[ra_i];
  assign rdb_o  = memory[rb_i];
  assign we_eff = we_i;
`endif
  // Reset clears every register; otherwise write back the executed value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) memory[i] <= '0;
    end else if (we_eff) begin
      memory[wa_i] <= wd_i;
    end
  end
endmodule

module ozer_alican_pr2_top (
  input logic             clk,
  input logic             rst,
  ozer_alican_pr2_if.slave bus
);
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                         F_SLT = 6'h2A, F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03,
                         F_SLLV = 6'h04;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] a, b, sra_v, alu, result_d, result_q;
  logic        valid;
  assign opcode = bus.instr[31:26];
  assign rs     = bus.instr[25:21];
  assign rt     = bus.instr[20:16];
  assign rd     = bus.instr[15:11];
  assign shamt  = bus.instr[10:6];
  assign funct  = bus.instr[5:0];
  assign sra_v  = $signed(b) >>> shamt;
  ozer_alican_pr2_regfile regMod (
    .clk   (clk),
    .rst   (rst),
    .we_i  (valid),
    .ra_i  (rs),
    .rb_i  (rt),
    .wa_i  (rd),
    .wd_i  (alu),
    .rda_o (a),
    .rdb_o (b)
  );
  // Decode funct and compute the ALU/shifter value; unsupported codes yield zero
  always_comb begin
    valid = (opcode == 6'd0) && (funct == F_ADD || funct == F_SUB || funct == F_AND ||
            funct == F_OR || funct == F_SLT || funct == F_SLL || funct == F_SRL ||
            funct == F_SRA || funct == F_SLLV);
    alu = funct == F_ADD  ? a + b :
          funct == F_SUB  ? a - b :
          funct == F_AND  ? a & b :
          funct == F_OR   ? a | b :
          funct == F_SLT  ? {31'd0, $signed(a) < $signed(b)} :
          funct == F_SLL  ? b << shamt :
          funct == F_SRL  ? b >> shamt :
          funct == F_SRA  ? sra_v :
          funct == F_SLLV ? b << a[4:0] : 32'd0;
    result_d = valid ? alu : 32'd0;
  end
  // Register the executed value; reset wins
  always_ff @(posedge clk) begin
    result_q <= rst ? 32'd0 : result_d;
  end
  assign bus.result = result_q;
endmodule

// File: tb/tb_ozer_alican_pr2_top.sv
// tb_ozer_alican_pr2_top: directed scoreboard bench for the R-type execute block
module tb_ozer_alican_pr2_top;
  localparam logic [31:0] INV = 32'hFC00_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];
  ozer_alican_pr2_if bus ();
  ozer_alican_pr2_top dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] rt_ins(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
    rt_ins = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_reg(input int idx, input logic [31:0] v);
    dut.regMod.memory[idx] = v;
  endtask

  task automatic exec(input string tag, input logic [31:0] ins, input logic [31:0] expv);
    logic [31:0] e;
    @(negedge clk);
    bus.instr = ins;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, bus.result, e);
    end
    bus.instr = INV;
  endtask

  initial begin
    int nz;
    bus.instr = INV;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    set_reg(4, 32'h1234);
    set_reg(20, 32'hDEAD);
    exec("pre_add", rt_ins(4, 20, 7, 0, 6'h20), 32'h1234 + 32'hDEAD);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_result", bus.result, 32'd0);
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.regMod.memory[i] !== 32'd0) nz++;
    chk("reset_regs_nonzero", 32'(nz), 32'd0);
    set_reg(0, 32'd0);
    set_reg(3, 32'd5);
    exec("add", 32'h0003_D0E0, 32'd5);
    chk("add_r26", dut.regMod.memory[26], 32'd5);
    set_reg(1, 32'd3);
    set_reg(2, 32'd5);
    exec("sub", 32'h0022_1822, 32'hFFFF_FFFE);
    chk("sub_r3", dut.regMod.memory[3], 32'hFFFF_FFFE);
    set_reg(8, 32'h8000_0010);
    exec("sra", 32'h00E8_F8C3, 32'hF000_0002);
    chk("sra_r31", dut.regMod.memory[31], 32'hF000_0002);
    exec("srl", 32'h00E8_F8C2, 32'h1000_0002);
    set_reg(5, 32'hFFFF_FFFF);
    set_reg(4, 32'd1);
    exec("slt_neg", 32'h00A4_F8EA, 32'd1);
    exec("slt_pos", rt_ins(4, 5, 9, 0, 6'h2A), 32'd0);
    set_reg(11, 32'h24);
    set_reg(3, 32'd1);
    exec("sllv", 32'h0163_78C4, 32'h10);
    chk("sllv_r15", dut.regMod.memory[15], 32'h10);
    set_reg(12, 32'hF0F0_1234);
    set_reg(13, 32'h0FF0_FF00);
    exec("and", rt_ins(12, 13, 14, 0, 6'h24), 32'h00F0_1200);
    exec("or", rt_ins(12, 13, 14, 0, 6'h25), 32'hFFF0_FF34);
    exec("sll3", rt_ins(0, 12, 16, 3, 6'h00), 32'h8780_91A0);
    exec("sll0", rt_ins(0, 12, 16, 0, 6'h00), 32'hF0F0_1234);
    set_reg(17, 32'hFFFF_FFFF);
    exec("add_wrap", rt_ins(17, 4, 18, 0, 6'h20), 32'd0);
    set_reg(1, 32'd3);
    exec("rbw_1", rt_ins(1, 1, 1, 0, 6'h20), 32'd6);
    exec("rbw_2", rt_ins(1, 1, 1, 0, 6'h20), 32'd12);
    chk("rbw_r1", dut.regMod.memory[1], 32'd12);
`ifdef PR2_ZERO_REG_EN
    exec("zero_add", rt_ins(12, 4, 0, 0, 6'h20), 32'hF0F0_1235);
    chk("zero_r0", dut.regMod.memory[0], 32'd0);
`else
    exec("r0_add", rt_ins(12, 4, 0, 0, 6'h20), 32'hF0F0_1235);
    chk("r0_write", dut.regMod.memory[0], 32'hF0F0_1235);
`endif
    set_reg(3, 32'h5555_AAAA);
    exec("inv_opcode", 32'h2022_1822, 32'd0);
    chk("inv_opcode_r3", dut.regMod.memory[3], 32'h5555_AAAA);
    exec("pre_inv", rt_ins(12, 13, 14, 0, 6'h25), 32'hFFF0_FF34);
    exec("inv_funct", 32'h0022_183F, 32'd0);
    chk("inv_funct_r3", dut.regMod.memory[3], 32'h5555_AAAA);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
